// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage ahead of the decoder.
// Keeps the PC and has at most one instruction-memory request outstanding
// (req/gnt/rvalid). It holds the fetched word for decode (valid/ready) and
// redirects on taken branches, JAL and JALR.
// Build option: define IFU_MISALIGN_CHK_EN to make a misaligned redirect target
// latch misaligned_err and park the unit in HALT. Without it, target[1:0] is
// forced to 00 and misaligned_err is tied low.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  input  logic            ex_branch,
  input  logic            ex_zero,
  input  logic [1:0]      ex_j,
  input  logic [XLEN-1:0] ex_pc_target,
  input  logic [XLEN-1:0] ex_alu_result,
  output logic            misaligned_err
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            drop_q;
  logic            req_q;
  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic [XLEN-1:0] instr_pc_plus4_q;

  logic            redirect_d;
  logic [XLEN-1:0] raw_target_d;
  logic [XLEN-1:0] target_d;
  logic [XLEN-1:0] pc_plus4_d;
`ifdef IFU_MISALIGN_CHK_EN
  logic            err_q;
  logic            misalign_d;
`endif

  // Redirect decode and target selection from the execute-stage control.
  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    redirect_d   = (ex_branch & ex_zero) | (ex_j == 2'b01) | (ex_j == 2'b10);
    raw_target_d = (ex_j == 2'b10) ? (ex_alu_result & ~XLEN'(1)) : ex_pc_target;
    pc_plus4_d   = pc_q + XLEN'(4);
`ifdef IFU_MISALIGN_CHK_EN
    target_d     = raw_target_d;
    misalign_d   = redirect_d & (raw_target_d[1:0] != 2'b00);
`else
    target_d     = raw_target_d & ~XLEN'(3);
`endif
  end

  // Fetch FSM: PC, request, drop bookkeeping and the registered decode outputs.
  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= REQ;
      pc_q             <= RESET_PC;
      drop_q           <= 1'b0;
      req_q            <= 1'b1;
      valid_q          <= 1'b0;
      // NOTE: the instruction datapath is reset because decode must see zeros after reset.
      instr_q          <= '0;
      instr_pc_q       <= '0;
      instr_pc_plus4_q <= '0;
`ifdef IFU_MISALIGN_CHK_EN
      err_q            <= 1'b0;
`endif
    end else begin
`ifdef IFU_MISALIGN_CHK_EN
      if (state_q != HALT && misalign_d) begin
        err_q   <= 1'b1;
        state_q <= HALT;
        req_q   <= 1'b0;
        valid_q <= 1'b0;
      end else
`endif
      case (state_q)
        REQ: begin
          if (redirect_d) begin
            pc_q <= target_d;
            if (imem_gnt) begin
              // The granted fetch is for the old PC: discard its data later.
              drop_q  <= 1'b1;
              state_q <= WAIT;
              req_q   <= 1'b0;
            end
          end else if (imem_gnt) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (drop_q || redirect_d) begin
              if (redirect_d) pc_q <= target_d;
              drop_q  <= 1'b0;
              state_q <= REQ;
              req_q   <= 1'b1;
            end else begin
              instr_q          <= imem_rdata;
              instr_pc_q       <= pc_q;
              instr_pc_plus4_q <= pc_plus4_d;
              state_q          <= HOLD;
              valid_q          <= 1'b1;
            end
          end else if (redirect_d) begin
            pc_q   <= target_d;
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          // A redirect wins over a same-cycle accept: the held instruction is squashed.
          if (redirect_d) begin
            pc_q    <= target_d;
            state_q <= REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end else if (instr_ready) begin
            pc_q    <= pc_plus4_d;
            state_q <= REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= REQ;
        end
      endcase
    end
  end

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign instr_valid    = valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_pc_plus4 = instr_pc_plus4_q;
`ifdef IFU_MISALIGN_CHK_EN
  assign misaligned_err = err_q;
`else
  assign misaligned_err = 1'b0;
`endif

endmodule
